// File: rtl/wb_arbiter.sv
// Writeback arbiter for the register file's single write port, with a
// per-register pending-write scoreboard for long-latency results.
module wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    input  logic        set_valid,
    input  logic [4:0]  set_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        stall,
    output logic [31:0] busy,
    output logic [4:0]  rd,
    output logic [31:0] write,
    output logic        reg_write
);

    localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);
    localparam logic [3:0] CNT_MAX = 4'd15;

    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] busy_q, busy_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] write_q, write_d;
    logic        reg_write_q, reg_write_d;

    logic        force_a;
    logic        a_xfer;
    logic        b_xfer;

    // B has fixed priority until A has been refused LIMIT cycles in a row.
    always_comb begin
        force_a = (cnt_q >= LIMIT);
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!reset) begin
            a_ready = !b_valid || force_a;
            b_ready = !(force_a && a_valid);
        end
        a_xfer = a_valid && a_ready;
        b_xfer = b_valid && b_ready;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!a_valid || a_xfer) begin
            cnt_d = 4'd0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // x0 transfers are consumed without raising the write enable.
    always_comb begin
        rd_d        = rd_q;
        write_d     = write_q;
        reg_write_d = 1'b0;
        if (b_xfer) begin
            rd_d        = b_rd;
            write_d     = b_data;
            reg_write_d = (b_rd != 5'd0);
        end else if (a_xfer) begin
            rd_d        = a_rd;
            write_d     = a_data;
            reg_write_d = (a_rd != 5'd0);
        end
    end

    // Set is applied after clear so a newly issued op keeps its register busy.
    always_comb begin
        busy_d = busy_q;
        if (b_xfer) begin
            busy_d[b_rd] = 1'b0;
        end
        if (set_valid && (set_rd != 5'd0)) begin
            busy_d[set_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= 4'd0;
            busy_q      <= 32'd0;
            rd_q        <= 5'd0;
            write_q     <= 32'd0;
            reg_write_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            rd_q        <= rd_d;
            write_q     <= write_d;
            reg_write_q <= reg_write_d;
        end
    end

    assign stall     = busy_q[rs1] | busy_q[rs2];
    assign busy      = busy_q;
    assign rd        = rd_q;
    assign write     = write_q;
    assign reg_write = reg_write_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected register-file writes are queued by
// the stimulus and popped by a monitor whenever reg_write is seen high.
module tb_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        a_valid, b_valid, set_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_rd, b_rd, set_rd, rs1, rs2;
    logic [31:0] a_data, b_data;
    logic        stall;
    logic [31:0] busy;
    logic [4:0]  rd;
    logic [31:0] write;
    logic        reg_write;

    int n_cmp = 0;
    int n_err = 0;
    logic [36:0] exp_q[$];

    wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .set_valid(set_valid), .set_rd(set_rd), .rs1(rs1), .rs2(rs2),
        .stall(stall), .busy(busy), .rd(rd), .write(write), .reg_write(reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [4:0] r, input logic [31:0] d);
        exp_q.push_back({r, d});
    endtask

    // Monitor: every observed write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reg_write === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%08h expected none", rd, write);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({rd, write} !== e) begin
                    n_err++;
                    $display("FAIL write: got rd=%0d data=0x%08h expected rd=%0d data=0x%08h",
                             rd, write, e[36:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h1;
        b_valid = 1'b1; b_rd = 5'd2; b_data = 32'h2;
        set_valid = 1'b0; set_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;

        // Reset with both producers requesting
        repeat (2) next_cycle();
        @(negedge clk);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        next_cycle();
        reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_write", write, 32'd0);
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_busy", busy, 32'd0);

        // Single A write
        next_cycle();
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("a_single_ready", 32'(a_ready), 32'd1);
        push_wr(5'd5, 32'hDEADBEEF);
        next_cycle();
        a_valid = 1'b0;
        @(negedge clk);
        chk("a_single_we", 32'(reg_write), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("a_single_we_off", 32'(reg_write), 32'd0);

        // Starvation: B wins 4 times, A forced on the 5th, then B again
        next_cycle();
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hA5A5A5A5;
        b_valid = 1'b1; b_rd = 5'd10; b_data = 32'hB0000000;
        for (int i = 0; i < 6; i++) begin
            logic exp_b;
            exp_b = (i != 4);
            @(negedge clk);
            chk($sformatf("starve_b_ready_%0d", i), 32'(b_ready), 32'(exp_b));
            chk($sformatf("starve_a_ready_%0d", i), 32'(a_ready), 32'(!exp_b));
            if (exp_b) push_wr(b_rd, b_data);
            else       push_wr(a_rd, a_data);
            next_cycle();
            if (exp_b) b_data = b_data + 32'd1;
            else       a_data = 32'h12345678;
        end
        b_valid = 1'b0;
        @(negedge clk);
        chk("starve_a_alone", 32'(a_ready), 32'd1);
        push_wr(5'd3, 32'h12345678);
        next_cycle();
        a_valid = 1'b0;

        // x0 write consumed silently
        next_cycle();
        b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h55;
        @(negedge clk);
        chk("x0_b_ready", 32'(b_ready), 32'd1);
        next_cycle();
        b_valid = 1'b0;
        @(negedge clk);
        chk("x0_reg_write", 32'(reg_write), 32'd0);
        chk("x0_busy", busy, 32'd0);

        // Scoreboard set, stall, clear
        next_cycle();
        set_valid = 1'b1; set_rd = 5'd7; rs1 = 5'd7;
        @(negedge clk);
        chk("sb_stall_same_cycle", 32'(stall), 32'd0);
        next_cycle();
        set_valid = 1'b0;
        @(negedge clk);
        chk("sb_busy_set", busy, 32'h0000_0080);
        chk("sb_stall_rs1", 32'(stall), 32'd1);
        next_cycle();
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h77;
        @(negedge clk);
        chk("sb_stall_before_clear", 32'(stall), 32'd1);
        chk("sb_clear_b_ready", 32'(b_ready), 32'd1);
        push_wr(5'd7, 32'h77);
        next_cycle();
        b_valid = 1'b0;
        @(negedge clk);
        chk("sb_busy_clear", busy, 32'd0);
        chk("sb_stall_clear", 32'(stall), 32'd0);

        // Same-cycle set and clear: set wins
        next_cycle();
        rs1 = 5'd0;
        set_valid = 1'b1; set_rd = 5'd9;
        b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h99;
        @(negedge clk);
        push_wr(5'd9, 32'h99);
        next_cycle();
        b_valid = 1'b0; set_rd = 5'd0; rs2 = 5'd9;
        @(negedge clk);
        chk("simul_busy", busy, 32'h0000_0200);
        chk("simul_stall_rs2", 32'(stall), 32'd1);
        next_cycle();
        set_valid = 1'b0;
        @(negedge clk);
        chk("set_x0_busy", busy, 32'h0000_0200);

        // Mid-stream reset clears scoreboard and write stage
        next_cycle();
        reset = 1'b1; a_valid = 1'b1; a_rd = 5'd4; a_data = 32'hCAFE;
        @(negedge clk);
        chk("mid_rst_a_ready", 32'(a_ready), 32'd0);
        next_cycle();
        reset = 1'b0; a_valid = 1'b0; rs2 = 5'd0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 32'd0);
        chk("mid_rst_reg_write", 32'(reg_write), 32'd0);
        chk("mid_rst_rd", 32'(rd), 32'd0);
        chk("mid_rst_write", write, 32'd0);

        repeat (2) next_cycle();
        @(negedge clk);
        chk("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
